// File: rtl/spike_event_encoder.sv
// spike_event_encoder: captures a 16-bit firing vector on each REQ pulse, tags it
// with a timestep and emits one address event per set bit (lowest index first)
// through an internal DEPTH-entry FIFO with a valid/ready output.
// Latency: capture at edge n, first push at edge n+1; one event per cycle.
// Backpressure: full FIFO stalls encoding; a REQ that cannot be captured is dropped (OVF).
// Ports: CLK/RSTB clock and async active-low reset; REQ/NEURON_OUT vector input;
//   TS_CLR/OVF_CLR sync clears; EV_VALID/EV_READY/EV_ADDR/EV_TS event output;
//   BUSY (encoding), OVF (sticky drop flag), FIFO_CNT (occupancy).
// Optional macro SPIKE_STAT_EN adds SPIKE_CNT (pushed events) and DROP_CNT (dropped REQs).
module spike_event_encoder #(
  parameter int DEPTH    = 8,
  parameter int TS_WIDTH = 8
) (
  input  logic                    CLK,
  input  logic                    RSTB,
  input  logic                    REQ,
  input  logic [15:0]             NEURON_OUT,
  input  logic                    TS_CLR,
  input  logic                    OVF_CLR,
  output logic                    EV_VALID,
  input  logic                    EV_READY,
  output logic [3:0]              EV_ADDR,
  output logic [TS_WIDTH-1:0]     EV_TS,
  output logic                    BUSY,
  output logic                    OVF,
`ifdef SPIKE_STAT_EN
  output logic [15:0]             SPIKE_CNT,
  output logic [7:0]              DROP_CNT,
`endif
  output logic [$clog2(DEPTH):0]  FIFO_CNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 4 + TS_WIDTH;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  typedef enum logic {IDLE, ENCODE} state_t;

  state_t              state;
  logic [15:0]         pend;
  logic [TS_WIDTH-1:0] tag;
  logic [TS_WIDTH-1:0] ts;
  logic [EW-1:0]       mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         cnt;

  logic                ev_vld;
  logic                pop;
  logic                push;
  logic                last;
  logic                accept;
  logic                capture;
  logic                drop;
  logic [15:0]         pend_clr;
  logic [3:0]          push_addr;
  logic [TS_WIDTH-1:0] cur_tag;
  logic [EW-1:0]       head;

  function automatic logic [3:0] low_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  assign ev_vld    = (cnt != '0);
  assign pop       = ev_vld & EV_READY;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push      = (state == ENCODE) && ((cnt != FULL_CNT) || pop);
  assign push_addr = low_idx(pend);
  assign pend_clr  = pend & (pend - 16'd1);
  assign last      = push && (pend_clr == '0);
  // A new vector fits only when the pending one is finishing this very cycle.
  assign accept    = REQ && ((state == IDLE) || last);
  assign drop      = REQ && !accept;
  assign capture   = accept && (NEURON_OUT != '0);
  assign cur_tag   = TS_CLR ? '0 : ts;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state  <= IDLE;
      pend   <= '0;
      tag    <= '0;
      ts     <= '0;
      OVF    <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (TS_CLR)   ts <= REQ ? TS_WIDTH'(1) : '0;
      else if (REQ) ts <= ts + TS_WIDTH'(1);

      if (capture) begin
        pend  <= NEURON_OUT;
        tag   <= cur_tag;
        state <= ENCODE;
      end else begin
        if (push) pend  <= pend_clr;
        if (last) state <= IDLE;
      end

      if (drop)         OVF <= 1'b1;
      else if (OVF_CLR) OVF <= 1'b0;

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset; outputs are masked by EV_VALID instead.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= {push_addr, tag};
  end

  assign head     = ev_vld ? mem[rd_ptr] : '0;
  assign EV_VALID = ev_vld;
  assign EV_ADDR  = head[EW-1:TS_WIDTH];
  assign EV_TS    = head[TS_WIDTH-1:0];
  assign BUSY     = (state == ENCODE);
  assign FIFO_CNT = cnt;

`ifdef SPIKE_STAT_EN
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      SPIKE_CNT <= '0;
      DROP_CNT  <= '0;
    end else begin
      if (TS_CLR)                          SPIKE_CNT <= push ? 16'd1 : 16'd0;
      else if (push && SPIKE_CNT != 16'hFFFF) SPIKE_CNT <= SPIKE_CNT + 16'd1;

      if (OVF_CLR)                         DROP_CNT <= drop ? 8'd1 : 8'd0;
      else if (drop && DROP_CNT != 8'hFF)  DROP_CNT <= DROP_CNT + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spike_event_encoder.sv
// tb_spike_event_encoder: directed stimulus with an event scoreboard for spike_event_encoder.
// Expected {addr, ts} pairs are queued as vectors are driven and compared when the
// DUT hands an event over (EV_VALID & EV_READY sampled on the falling edge).
module tb_spike_event_encoder;

  logic        CLK = 1'b0;
  logic        RSTB;
  logic        REQ;
  logic [15:0] NEURON_OUT;
  logic        TS_CLR;
  logic        OVF_CLR;
  logic        EV_VALID;
  logic        EV_READY;
  logic [3:0]  EV_ADDR;
  logic [7:0]  EV_TS;
  logic        BUSY;
  logic        OVF;
  logic [3:0]  FIFO_CNT;
`ifdef SPIKE_STAT_EN
  logic [15:0] SPIKE_CNT;
  logic [7:0]  DROP_CNT;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] q[$];
  logic [31:0] mon_exp;
  int          busy_n;

  spike_event_encoder #(.DEPTH(8), .TS_WIDTH(8)) dut (
    .CLK(CLK), .RSTB(RSTB), .REQ(REQ), .NEURON_OUT(NEURON_OUT),
    .TS_CLR(TS_CLR), .OVF_CLR(OVF_CLR),
    .EV_VALID(EV_VALID), .EV_READY(EV_READY), .EV_ADDR(EV_ADDR), .EV_TS(EV_TS),
    .BUSY(BUSY), .OVF(OVF),
`ifdef SPIKE_STAT_EN
    .SPIKE_CNT(SPIKE_CNT), .DROP_CNT(DROP_CNT),
`endif
    .FIFO_CNT(FIFO_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer
  always @(negedge CLK) begin
    if (RSTB && EV_VALID && EV_READY) begin
      if (q.size() == 0) begin
        chk("unexpected_event", 32'({EV_ADDR, EV_TS}), 32'hFFFF_FFFF);
      end else begin
        mon_exp = q.pop_front();
        chk("event", 32'({EV_ADDR, EV_TS}), mon_exp);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic exp_ev(input int addr, input int tsv);
    q.push_back(32'(addr * 256 + tsv));
  endtask

  task automatic do_req(input logic [15:0] v);
    REQ = 1'b1;
    NEURON_OUT = v;
    step();
    REQ = 1'b0;
    NEURON_OUT = '0;
  endtask

  task automatic do_reset();
    REQ = 1'b0; TS_CLR = 1'b0; OVF_CLR = 1'b0; NEURON_OUT = '0;
    RSTB = 1'b0;
    q.delete();
    step();
    step();
    RSTB = 1'b1;
    step();
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (q.size() == 0 && FIFO_CNT == 0 && !BUSY) break;
      step();
    end
    chk({tag, "_left"}, 32'(q.size()), 0);
    chk({tag, "_cnt"}, 32'(FIFO_CNT), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    REQ = 1'b0; TS_CLR = 1'b0; OVF_CLR = 1'b0; EV_READY = 1'b0; NEURON_OUT = '0;
    RSTB = 1'b1;
    #2 RSTB = 1'b0;
    #10;
    chk("rst_valid", 32'(EV_VALID), 0);
    chk("rst_addr",  32'(EV_ADDR), 0);
    chk("rst_ts",    32'(EV_TS), 0);
    chk("rst_busy",  32'(BUSY), 0);
    chk("rst_ovf",   32'(OVF), 0);
    chk("rst_cnt",   32'(FIFO_CNT), 0);
    step();
    RSTB = 1'b1;
    step();

    // Basic encode, latency and BUSY duration
    EV_READY = 1'b1;
    exp_ev(0, 0); exp_ev(5, 0); exp_ev(10, 0); exp_ev(15, 0);
    do_req(16'h8421);
    chk("t1_busy_capture",  32'(BUSY), 1);
    chk("t1_valid_capture", 32'(EV_VALID), 0);
    step();
    chk("t1_valid_next", 32'(EV_VALID), 1);
    busy_n = 1;
    for (int i = 0; i < 10; i++) begin
      if (BUSY) busy_n++;
      step();
    end
    chk("t1_busy_cycles", 32'(busy_n), 4);
    drain("t1_drain", 5);

    // Full FIFO stalls encoding; drain all 16 in order
    EV_READY = 1'b0;
    for (int i = 0; i < 16; i++) exp_ev(i, 1);
    do_req(16'hFFFF);
    repeat (12) step();
    chk("t2_full_cnt", 32'(FIFO_CNT), 8);
    chk("t2_busy",     32'(BUSY), 1);
    chk("t2_valid",    32'(EV_VALID), 1);
    chk("t2_head",     32'({EV_ADDR, EV_TS}), 32'h001);
    step();
    chk("t2_head_hold", 32'({EV_ADDR, EV_TS}), 32'h001);
    EV_READY = 1'b1;
    drain("t2_drain", 40);
    chk("t2_idle", 32'(BUSY), 0);

    // Drop while encoding, OVF set/clear and drop-vs-clear priority
    do_reset();
    EV_READY = 1'b1;
    for (int i = 0; i < 8; i++) exp_ev(i, 0);
    do_req(16'h00FF);
    step();
    step();
    do_req(16'h0001);
    chk("t3_ovf_set", 32'(OVF), 1);
    OVF_CLR = 1'b1;
    step();
    OVF_CLR = 1'b0;
    chk("t3_ovf_clr", 32'(OVF), 0);
    REQ = 1'b1; NEURON_OUT = 16'h0001; OVF_CLR = 1'b1;
    step();
    REQ = 1'b0; NEURON_OUT = '0; OVF_CLR = 1'b0;
    chk("t3_ovf_drop_wins", 32'(OVF), 1);
    OVF_CLR = 1'b1;
    step();
    OVF_CLR = 1'b0;
    chk("t3_ovf_clr2", 32'(OVF), 0);
    drain("t3_drain", 20);
    exp_ev(0, 3);
    do_req(16'h0001);
    drain("t3_drain2", 5);

    // Back-to-back accept on the last push
    do_reset();
    EV_READY = 1'b1;
    exp_ev(0, 0); exp_ev(1, 0); exp_ev(4, 1);
    do_req(16'h0003);
    step();
    do_req(16'h0010);
    chk("t4_busy", 32'(BUSY), 1);
    chk("t4_ovf",  32'(OVF), 0);
    drain("t4_drain", 10);
    chk("t4_ovf_end", 32'(OVF), 0);

    // Timestep wrap, TS_CLR with REQ, zero vector
    do_reset();
    EV_READY = 1'b1;
    REQ = 1'b1;
    NEURON_OUT = '0;
    repeat (255) step();
    REQ = 1'b0;
    chk("t5_zero_busy", 32'(BUSY), 0);
    chk("t5_zero_cnt",  32'(FIFO_CNT), 0);
    exp_ev(2, 255);
    do_req(16'h0004);
    drain("t5_d1", 5);
    exp_ev(3, 0);
    do_req(16'h0008);
    drain("t5_d2", 5);
    REQ = 1'b1;
    repeat (3) step();
    REQ = 1'b0;
    exp_ev(1, 0);
    TS_CLR = 1'b1;
    do_req(16'h0002);
    TS_CLR = 1'b0;
    drain("t5_d3", 5);
    do_req(16'h0000);
    chk("t5_zero2_cnt",   32'(FIFO_CNT), 0);
    chk("t5_zero2_valid", 32'(EV_VALID), 0);
    chk("t5_zero2_busy",  32'(BUSY), 0);
    exp_ev(0, 2);
    do_req(16'h0001);
    drain("t5_d4", 5);

    // Asynchronous reset mid-encode
    do_reset();
    EV_READY = 1'b0;
    do_req(16'hFFFF);
    for (int i = 0; i < 20; i++) begin
      if (FIFO_CNT == 5) break;
      step();
    end
    chk("t6_cnt5", 32'(FIFO_CNT), 5);
    #2 RSTB = 1'b0;
    #1;
    q.delete();
    chk("t6_valid", 32'(EV_VALID), 0);
    chk("t6_addr",  32'(EV_ADDR), 0);
    chk("t6_ts",    32'(EV_TS), 0);
    chk("t6_busy",  32'(BUSY), 0);
    chk("t6_ovf",   32'(OVF), 0);
    chk("t6_cnt",   32'(FIFO_CNT), 0);
    step();
    RSTB = 1'b1;
    EV_READY = 1'b1;
    step();
    exp_ev(4, 0);
    do_req(16'h0010);
    drain("t6_drain", 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spike_event_encoder.md
Name: spike_event_encoder

Overview:
- Downstream of the CIM macro.
- Captures the 16-bit neuron firing vector on each single-cycle REQ pulse, tags it with a timestep index, and serializes set bits into address events, lowest index first.
- Buffers events in an internal FIFO and presents them on a valid/ready interface to the output/router stage.

Parameters:
DEPTH, 8, event FIFO entries; power of two, >=2
TS_WIDTH, 8, timestep tag width

Ports:
CLK  input  1  clock
RSTB  input  1  asynchronous active-low reset
REQ  input  1  single-cycle pulse: NEURON_OUT valid this cycle
NEURON_OUT  input  16  firing vector, bit i = neuron i fired
TS_CLR  input  1  synchronous clear of timestep counter
OVF_CLR  input  1  synchronous clear of OVF flag
EV_VALID  output  1  event available at FIFO head
EV_READY  input  1  consumer accepts head event when EV_VALID=1
EV_ADDR  output  4  neuron index of head event
EV_TS  output  TS_WIDTH  timestep tag of head event
BUSY  output  1  encoder in ENCODE state
OVF  output  1  sticky: a REQ vector was dropped
FIFO_CNT  output  log2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (RSTB low, asynchronous):
  - state=IDLE, pending vector=0, timestep counter=0, FIFO empty.
  - EV_VALID=0, EV_ADDR=0, EV_TS=0, BUSY=0, OVF=0, FIFO_CNT=0.
  - Reset mid-encode discards the pending vector and all FIFO contents.
- Timestep counter ts:
  - Increments by 1 on every REQ, whether the vector is accepted or dropped.
  - Wraps from 2^TS_WIDTH-1 to 0.
  - TS_CLR takes priority over increment.
  - If TS_CLR and REQ occur in the same cycle, the vector is tagged 0 and ts becomes 1.
  - A captured vector is tagged with the ts value before the increment.
- State machine:
  - IDLE:
    - REQ with NEURON_OUT!=0: capture vector and tag, go to ENCODE.
    - REQ with NEURON_OUT==0: nothing is pushed, ts still increments, stay in IDLE.
  - ENCODE:
    - Each cycle a push is allowed if FIFO_CNT<DEPTH, or if FIFO_CNT==DEPTH and a pop occurs the same cycle.
    - On a push, write {lowest set bit index, tag} and clear that bit.
    - After the push that clears the last bit, go to IDLE.
    - If the push is blocked, the vector is held and the state does not change.
- REQ while in ENCODE:
  - Accepted only in the cycle whose push clears the last pending bit; it is captured as in IDLE and the state stays ENCODE if the new vector is nonzero.
  - Otherwise the vector is dropped and OVF is set.
  - OVF_CLR clears OVF. If a drop and OVF_CLR occur in the same cycle, OVF=1.
- Latency and throughput:
  - REQ captured at edge n gives the first push at edge n+1, so EV_VALID=1 after edge n+1.
  - Throughput is one event per cycle.
  - A vector with k set bits occupies ENCODE for k cycles when the FIFO is unblocked.
- FIFO:
  - Pop occurs when EV_VALID & EV_READY.
  - EV_ADDR and EV_TS are driven combinationally from head storage.
  - EV_VALID = (FIFO_CNT!=0).
  - Simultaneous push and pop leaves FIFO_CNT unchanged.
  - Pointers wrap modulo DEPTH.
  - EV_READY while empty has no effect.
  - Head outputs are held stable while EV_VALID=1 and EV_READY=0.
- BUSY = (state==ENCODE).

Optional Feature:
SPIKE_STAT_EN
- Defined: adds output SPIKE_CNT [15:0].
  - Counts events pushed into the FIFO, saturating at 16'hFFFF.
  - Cleared by RSTB and by TS_CLR; a push in a TS_CLR cycle yields SPIKE_CNT=1.
  - Adds output DROP_CNT [7:0]: dropped-REQ count, saturating at 8'hFF, cleared by OVF_CLR.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Reset, then REQ with NEURON_OUT=16'h8421, EV_READY=1 -> events (0,0),(5,0),(10,0),(15,0) on consecutive cycles; first EV_VALID one cycle after the capture edge; BUSY high for 4 cycles.
- EV_READY=0, REQ with 16'hFFFF, DEPTH=8 -> FIFO_CNT reaches 8 and BUSY stays 1; raising EV_READY drains 16 events in order 0..15; none lost, none duplicated.
- REQ 16'h00FF, then a second REQ 3 cycles later with 16'h0001 -> second vector dropped, OVF=1, ts=2; OVF_CLR -> OVF=0.
- Back-to-back: REQ 16'h0003, then REQ 16'h0010 timed to the cycle the last bit of the first vector is pushed -> events (0,0),(1,0),(4,1); OVF stays 0.
- TS_CLR plus REQ 16'h0002 in the same cycle, after 255 prior REQs with TS_WIDTH=8 -> event (1,0); then REQ 16'h0000 leaves the FIFO unchanged and ts becomes 2.
- RSTB asserted mid-encode with FIFO_CNT=5 -> all outputs 0 immediately; a subsequent REQ is encoded normally with tag 0.
